// File: rtl/hazard_field.sv
`default_nettype none
// ============================================================================
// Module   : hazard_field
// Purpose  : Manages NUM_HAZARDS hazard slots on the snake playfield. Hazards
//            spawn at pseudo-random free cells chosen by a 32-bit Galois LFSR.
//            Each hazard ages out after LIFETIME play cycles. A head collision
//            produces a one-cycle length-reduction pulse and opens an
//            immunity window.
// Ports    : clk           - system clock
//            rst           - asynchronous active-low reset
//            game_status   - 00 RESTART, 01 START, 10 PLAY, 11 as START
//            head_x/head_y - snake head coordinates
//            haz_x/haz_y   - packed slot coordinates, slot i at [i*COORD_W +: COORD_W]
//            haz_active    - per-slot active flags
//            hazard_count  - number of active slots
//            reduce_length - one-cycle pulse per hit
//            hit_index     - slot index of the most recent hit
//            immune        - high during the recovery window
// Revision : 1.0 - initial release
// ============================================================================
module hazard_field #(
  parameter int          NUM_HAZARDS    = 4,
  parameter int          COORD_W        = 6,
  parameter int          X_MAX          = 37,
  parameter int          Y_MAX          = 27,
  parameter int          SPAWN_INTERVAL = 25_000_000,
  parameter int          LIFETIME       = 100_000_000,
  parameter int          RECOVERY       = 5_000_000,
  parameter logic [31:0] LFSR_SEED      = 32'hACE12468
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     game_status,
  input  logic [COORD_W-1:0]             head_x,
  input  logic [COORD_W-1:0]             head_y,
  output logic [NUM_HAZARDS*COORD_W-1:0] haz_x,
  output logic [NUM_HAZARDS*COORD_W-1:0] haz_y,
  output logic [NUM_HAZARDS-1:0]         haz_active,
  output logic [4:0]                     hazard_count,
  output logic                           reduce_length,
  output logic [3:0]                     hit_index,
  output logic                           immune
);

  localparam int c_TMR_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int c_AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam int c_REC_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'((SPAWN_INTERVAL > 0) ? SPAWN_INTERVAL - 1 : 0);
  localparam logic [c_AGE_W-1:0] c_AGE_LAST  = c_AGE_W'((LIFETIME > 0) ? LIFETIME - 1 : 0);
  localparam logic [c_REC_W-1:0] c_REC_LAST  = c_REC_W'((RECOVERY > 0) ? RECOVERY - 1 : 0);
  localparam logic               c_EXPIRY_EN = (LIFETIME > 0);

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] c_LFSR_TAPS  = 32'h8020_0003;
  localparam logic [1:0]  c_GS_RESTART = 2'b00;
  localparam logic [1:0]  c_GS_PLAY    = 2'b10;

  // Registered state
  logic [31:0]            r_lfsr;
  logic [c_TMR_W-1:0]     r_timer;
  logic [COORD_W-1:0]     r_x   [NUM_HAZARDS];
  logic [COORD_W-1:0]     r_y   [NUM_HAZARDS];
  logic [c_AGE_W-1:0]     r_age [NUM_HAZARDS];
  logic [NUM_HAZARDS-1:0] r_active;
  logic [4:0]             r_count;
  logic                   r_reduce;
  logic [3:0]             r_hit_idx;
  logic                   r_immune;
  logic [c_REC_W-1:0]     r_rec;

  // Combinational decode
  logic                   w_play;
  logic                   w_restart;
  logic [31:0]            w_lfsr_nxt;
  logic [15:0]            w_mod_x;
  logic [15:0]            w_mod_y;
  logic [COORD_W-1:0]     w_cand_x;
  logic [COORD_W-1:0]     w_cand_y;
  logic [NUM_HAZARDS-1:0] w_match;
  logic [NUM_HAZARDS-1:0] w_expire;
  logic [NUM_HAZARDS-1:0] w_hit_oh;
  logic [NUM_HAZARDS-1:0] w_free_oh;
  logic [NUM_HAZARDS-1:0] w_active_nxt;
  logic                   w_hit_any;
  logic                   w_free_any;
  logic                   w_occupied;
  logic                   w_head_on_cand;
  logic                   w_hit;
  logic                   w_spawn;
  logic [3:0]             w_hit_idx;
  logic [4:0]             w_count_nxt;

  assign w_play     = (game_status == c_GS_PLAY);
  assign w_restart  = (game_status == c_GS_RESTART);
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'h0);

  // Candidate cell from the current LFSR value, mapped into 1..MAX
  assign w_mod_x  = r_lfsr[15:0]  % 16'(X_MAX);
  assign w_mod_y  = r_lfsr[31:16] % 16'(Y_MAX);
  assign w_cand_x = COORD_W'(w_mod_x + 16'd1);
  assign w_cand_y = COORD_W'(w_mod_y + 16'd1);

  // Per-slot match/expiry flags and lowest-index priority picks. The hit and
  // free-slot picks both use the pre-edge active mask, so a spawn can never
  // land in a slot that is being cleared on the same edge.
  always_comb begin
    w_match    = '0;
    w_expire   = '0;
    w_occupied = 1'b0;
    w_hit_oh   = '0;
    w_hit_any  = 1'b0;
    w_hit_idx  = '0;
    w_free_oh  = '0;
    w_free_any = 1'b0;
    for (int i = 0; i < NUM_HAZARDS; i++) begin
      w_match[i]  = r_active[i] && (r_x[i] == head_x) && (r_y[i] == head_y);
      w_expire[i] = c_EXPIRY_EN && r_active[i] && (r_age[i] == c_AGE_LAST);
      if (r_active[i] && (r_x[i] == w_cand_x) && (r_y[i] == w_cand_y)) begin
        w_occupied = 1'b1;
      end
      if (w_match[i] && !w_hit_any) begin
        w_hit_any   = 1'b1;
        w_hit_oh[i] = 1'b1;
        w_hit_idx   = 4'(i);
      end
      if (!r_active[i] && !w_free_any) begin
        w_free_any   = 1'b1;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  // Next active mask and its population count. The count is registered from
  // the same next-state mask so it always agrees with haz_active.
  always_comb begin
    w_head_on_cand = (head_x == w_cand_x) && (head_y == w_cand_y);
    w_hit          = w_play && !r_immune && w_hit_any;
    w_spawn        = w_play && (r_timer == c_TMR_LAST) && w_free_any &&
                     !w_head_on_cand && !w_occupied;
    w_active_nxt   = r_active;
    if (w_restart) begin
      w_active_nxt = '0;
    end else if (w_play) begin
      // A hit and an expiry on the same slot both clear it; the hit still
      // produces its pulse because w_hit does not depend on expiry.
      w_active_nxt = r_active & ~w_expire;
      if (w_hit) begin
        w_active_nxt = w_active_nxt & ~w_hit_oh;
      end
      if (w_spawn) begin
        w_active_nxt = w_active_nxt | w_free_oh;
      end
    end
    w_count_nxt = '0;
    for (int i = 0; i < NUM_HAZARDS; i++) begin
      w_count_nxt = w_count_nxt + 5'(w_active_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr    <= LFSR_SEED;
      r_timer   <= '0;
      r_active  <= '0;
      r_count   <= '0;
      r_reduce  <= 1'b0;
      r_hit_idx <= '0;
      r_immune  <= 1'b0;
      r_rec     <= '0;
      for (int i = 0; i < NUM_HAZARDS; i++) begin
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_age[i] <= '0;
      end
    end else begin
      // LFSR free-runs in every mode and is not reloaded by RESTART
      r_lfsr   <= w_lfsr_nxt;
      r_active <= w_active_nxt;
      r_count  <= w_count_nxt;
      r_reduce <= w_hit;
      if (w_restart) begin
        r_timer   <= '0;
        r_hit_idx <= '0;
        r_immune  <= 1'b0;
        r_rec     <= '0;
        for (int i = 0; i < NUM_HAZARDS; i++) begin
          r_x[i]   <= '0;
          r_y[i]   <= '0;
          r_age[i] <= '0;
        end
      end else if (w_play) begin
        // Timer parks at its terminal count until a candidate is accepted
        if (w_spawn) begin
          r_timer <= '0;
        end else if (r_timer != c_TMR_LAST) begin
          r_timer <= r_timer + c_TMR_W'(1);
        end
        for (int i = 0; i < NUM_HAZARDS; i++) begin
          if (w_spawn && w_free_oh[i]) begin
            r_x[i]   <= w_cand_x;
            r_y[i]   <= w_cand_y;
            r_age[i] <= '0;
          end else if (r_active[i]) begin
            r_age[i] <= r_age[i] + c_AGE_W'(1);
          end
        end
        if (w_hit) begin
          r_hit_idx <= w_hit_idx;
          r_immune  <= 1'b1;
          r_rec     <= '0;
        end else if (r_immune) begin
          if (r_rec == c_REC_LAST) begin
            r_immune <= 1'b0;
          end else begin
            r_rec <= r_rec + c_REC_W'(1);
          end
        end
      end
      // START / 11: state frozen apart from the LFSR and the pulse clearing
    end
  end

  generate
    for (genvar g = 0; g < NUM_HAZARDS; g++) begin : g_pack
      assign haz_x[g*COORD_W +: COORD_W] = r_x[g];
      assign haz_y[g*COORD_W +: COORD_W] = r_y[g];
    end
  endgenerate

  assign haz_active    = r_active;
  assign hazard_count  = r_count;
  assign reduce_length = r_reduce;
  assign hit_index     = r_hit_idx;
  assign immune        = r_immune;

endmodule
`default_nettype wire

// File: doc/hazard_field.md
Name: hazard_field

Overview:
- Parametrised successor to the fixed four-mine generator: manages NUM_HAZARDS hazard slots on the snake playfield.
- Spawns hazards at pseudo-random free cells using an internal LFSR, ages them out after a lifetime, and detects head collisions.
- On a collision it issues a one-cycle length-reduction pulse and opens an immunity window.
- Sits beside the snake movement and apple logic; outputs feed the VGA renderer and the length controller.

Parameters:
- NUM_HAZARDS, 4, number of hazard slots (1..16).
- COORD_W, 6, coordinate width in bits.
- X_MAX, 37, largest legal x; legal x range is 1..X_MAX.
- Y_MAX, 27, largest legal y; legal y range is 1..Y_MAX.
- SPAWN_INTERVAL, 25_000_000, PLAY cycles between spawn attempts.
- LIFETIME, 100_000_000, PLAY cycles a hazard stays active; 0 disables expiry.
- RECOVERY, 5_000_000, immunity cycles after a hit.
- LFSR_SEED, 32'hACE12468, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- game_status  in  2  00 RESTART, 01 START, 10 PLAY, 11 treated as START
- head_x  in  COORD_W  snake head x
- head_y  in  COORD_W  snake head y
- haz_x  out  NUM_HAZARDS*COORD_W  slot i x at bits [i*COORD_W +: COORD_W]
- haz_y  out  NUM_HAZARDS*COORD_W  slot i y, same packing
- haz_active  out  NUM_HAZARDS  per-slot active flag
- hazard_count  out  5  number of active slots
- reduce_length  out  1  one-cycle pulse per hit
- hit_index  out  4  slot index of the last hit; held until the next hit
- immune  out  1  high during the recovery window

Behaviour:
- Reset (rst low, async): all outputs 0, all timers and age counters 0, LFSR = LFSR_SEED.
- LFSR: 32-bit Galois, taps 32,22,2,1; advances every clk cycle in every game_status. RESTART does not reload it.
- RESTART: synchronously clears all outputs, timers and ages (same values as reset except the LFSR).
- START/11: everything frozen; outputs hold, no detection.
- PLAY, spawn:
  - spawn_timer increments each cycle up to SPAWN_INTERVAL-1, then holds there.
  - At the terminal count with a free slot: target slot = lowest-index inactive slot.
  - Candidate x = (lfsr[15:0] % X_MAX) + 1; candidate y = (lfsr[31:16] % Y_MAX) + 1.
  - Reject the candidate if it equals (head_x, head_y) or any active hazard's position. On reject, retry next cycle with the new LFSR value; timer stays at terminal.
  - On accept: write coordinates, set active, clear the slot's age, reset spawn_timer to 0.
  - All slots active: timer holds at terminal; spawn occurs the cycle after a slot frees.
- PLAY, expiry: each active slot's age increments per cycle. If LIFETIME>0 and age == LIFETIME-1, active clears next edge. Coordinates are retained but ignored.
- PLAY, collision (immune low):
  - Matching condition: active slot with haz_x==head_x and haz_y==head_y.
  - Lowest matching index is taken.
  - Next edge: slot deactivated, reduce_length=1 for exactly one cycle, hit_index=slot, immune=1, recovery counter=0.
  - Latency: one cycle from head match to pulse.
  - Other matching slots remain active and are evaluated after immunity ends.
- Immunity: recovery counter increments in PLAY; immune drops on the edge after the count reaches RECOVERY-1. No detection while immune. Spawn and expiry continue. Recovery counting pauses in START.
- Simultaneous events:
  - Hit and expiry on the same slot in the same cycle: hit wins (pulse issued).
  - Spawn and a hit/expiry in the same cycle: spawn uses the pre-edge active mask, so it never targets the slot being cleared.
- hazard_count: registered popcount of the next-state active mask, consistent with haz_active every cycle.
- Reset asserted mid-window: immediate clear, immune=0, no pulse.

Test Plan:
- Bench parameters: NUM_HAZARDS=4, SPAWN_INTERVAL=8, LIFETIME=40, RECOVERY=5; head parked at (0,0), PLAY held.
- Spawn order: first spawn on cycle 8 into slot 0, then slots 1,2,3 at 8-cycle spacing; all coordinates within 1..37 / 1..27; hazard_count reaches 4; no further spawns while full.
- Expiry: slot 0 active clears 40 cycles after its spawn; the next spawn refills slot 0 on the following cycle.
- Hit: drive head onto slot 2's coordinates -> one cycle later reduce_length=1 for 1 cycle, hit_index=2, haz_active[2]=0, immune high for 5 cycles. Keeping the head on a second overlapping hazard during immunity yields no pulse; a pulse follows after immune drops.
- Spawn rejection: force a candidate equal to the head or an existing hazard via a seed -> that candidate is never committed; a spawn occurs on a later cycle with distinct coordinates.
- Mode/reset: switch to START mid-lifetime -> ages and outputs frozen; RESTART -> all outputs 0. Assert rst while immune -> immune=0 asynchronously, no reduce_length pulse.
